// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard stall/flush control for the 5-stage MIPS pipeline.
// Covers what bypassing cannot resolve: load-use, branch operands needed in ID,
// and mult/div HI/LO occupancy. Stall/flush outputs are combinational.
// Optional macro STALL_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipeline_stall_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic       i_CLK,
  input  logic       i_RESET,
  input  logic [4:0] i_RsD,
  input  logic [4:0] i_RtD,
  input  logic       i_UseRtD,
  input  logic       i_BranchD,
  input  logic       i_BranchTakenD,
  input  logic       i_MDOpD,
  input  logic       i_HiLoReadD,
  input  logic       i_MemReadE,
  input  logic       i_RegWriteE,
  input  logic [4:0] i_RdE,
  input  logic       i_MDStartE,
  input  logic       i_MemReadM,
  input  logic [4:0] i_RdM,
  output logic       o_StallF,
  output logic       o_StallD,
  output logic       o_FlushD,
  output logic       o_FlushE,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0] o_StallCycles,
  output logic [31:0] o_FlushCycles,
`endif
  output logic       o_MDBusy
);

  typedef enum logic {IDLE, MD_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic w_hit_e, w_hit_m;
  logic w_load_use, w_branch_e, w_branch_m, w_md_haz;
  logic w_stall, w_flush;

  // Source-operand match against EX and MEM destinations; $0 never matches
  always_comb begin
    w_hit_e = (i_RdE != 5'd0) && ((i_RdE == i_RsD) || (i_UseRtD && (i_RdE == i_RtD)));
    w_hit_m = (i_RdM != 5'd0) && ((i_RdM == i_RsD) || (i_UseRtD && (i_RdM == i_RtD)));
  end

  // Hazard terms and gated stall/flush; reset forces all controls low.
  // A stalled branch compared stale operands, so it must not flush.
  always_comb begin
    w_load_use = i_MemReadE && w_hit_e;
    w_branch_e = i_BranchD && i_RegWriteE && w_hit_e;
    w_branch_m = i_BranchD && i_MemReadM && w_hit_m;
    w_md_haz   = (r_state == MD_WAIT) && (i_MDOpD || i_HiLoReadD);
    w_stall    = !i_RESET && (w_load_use || w_branch_e || w_branch_m || w_md_haz);
    w_flush    = !i_RESET && i_BranchD && i_BranchTakenD &&
                 !(w_load_use || w_branch_e || w_branch_m || w_md_haz);
    o_StallF   = w_stall;
    o_StallD   = w_stall;
    o_FlushE   = w_stall;
    o_FlushD   = w_flush;
  end

  // Mult/div occupancy next-state: load counter on issue, count down to 1, release
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_MDStartE) begin
          w_state_nxt = MD_WAIT;
          w_cnt_nxt   = CNT_W'(MD_LATENCY - 1);
        end
      end
      MD_WAIT: begin
        if (i_MDStartE) begin
          w_cnt_nxt = CNT_W'(MD_LATENCY - 1);
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_MDBusy = (r_state == MD_WAIT);

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_flush_cycles;

  // Saturating counts of stalled and flushed cycles
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush && (r_flush_cycles != 32'hFFFF_FFFF)) r_flush_cycles <= r_flush_cycles + 32'd1;
    end
  end

  assign o_StallCycles = r_stall_cycles;
  assign o_FlushCycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: per-scenario tasks drive per-cycle stimulus,
// push the expected output vector {StallF,StallD,FlushD,FlushE,MDBusy} into a
// scoreboard queue, and pop/compare at the falling edge.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs, rt, rdE, rdM;
  logic       usert, br, bt, mdop, hilo, memE, rwE, mds, memM;
  logic       stallF, stallD, flushD, flushE, mdbusy;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cyc, flush_cyc;
`endif

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MD_LATENCY(4), .CNT_W(4)) dut (
    .i_CLK(clk), .i_RESET(rst), .i_RsD(rs), .i_RtD(rt), .i_UseRtD(usert),
    .i_BranchD(br), .i_BranchTakenD(bt), .i_MDOpD(mdop), .i_HiLoReadD(hilo),
    .i_MemReadE(memE), .i_RegWriteE(rwE), .i_RdE(rdE), .i_MDStartE(mds),
    .i_MemReadM(memM), .i_RdM(rdM),
    .o_StallF(stallF), .o_StallD(stallD), .o_FlushD(flushD), .o_FlushE(flushE),
`ifdef STALL_PERF_CNT_EN
    .o_StallCycles(stall_cyc), .o_FlushCycles(flush_cyc),
`endif
    .o_MDBusy(mdbusy)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       usert, br, bt, mdop, hilo, memE, rwE;
    logic [4:0] rdE;
    logic       mds, memM;
    logic [4:0] rdM;
  } stim_t;

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b11010;
  localparam logic [4:0] BUSY  = 5'b00001;
  localparam logic [4:0] FLUSH = 5'b00100;

  logic [4:0] sb[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic stim_t S(logic r, logic [4:0] s_rs, logic [4:0] s_rt, logic s_ut,
                              logic s_br, logic s_bt, logic s_md, logic s_hl,
                              logic s_me, logic s_rw, logic [4:0] s_rde, logic s_mds,
                              logic s_mm, logic [4:0] s_rdm);
    stim_t s;
    s.rst = r; s.rs = s_rs; s.rt = s_rt; s.usert = s_ut; s.br = s_br; s.bt = s_bt;
    s.mdop = s_md; s.hilo = s_hl; s.memE = s_me; s.rwE = s_rw; s.rdE = s_rde;
    s.mds = s_mds; s.memM = s_mm; s.rdM = s_rdm;
    return s;
  endfunction

  task automatic drv(input stim_t s);
    rst = s.rst; rs = s.rs; rt = s.rt; usert = s.usert; br = s.br; bt = s.bt;
    mdop = s.mdop; hilo = s.hilo; memE = s.memE; rwE = s.rwE; rdE = s.rdE;
    mds = s.mds; memM = s.memM; rdM = s.rdM;
  endtask

  // All tasks start just after a rising edge and end just after a rising edge.
  task automatic test_reset();
    stim_t st[$]; logic [4:0] ex[$]; logic [4:0] got, e;
    st.push_back(S(1, 8, 0, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0)); ex.push_back(NONE); // load-use masked
    st.push_back(S(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(NONE); // taken branch masked
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(NONE);
    foreach (st[i]) begin
      drv(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = {stallF, stallD, flushD, flushE, mdbusy}; e = sb.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL reset step %0d: got %b expected %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$]; logic [4:0] ex[$]; logic [4:0] got, e;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] c0;
    c0 = stall_cyc;
`endif
    st.push_back(S(0, 8, 3, 1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0)); ex.push_back(STALL); // lw $8 ; use $8
    st.push_back(S(0, 8, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8)); ex.push_back(NONE);  // bubble in EX
    st.push_back(S(0, 3, 8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0)); ex.push_back(NONE);  // rt not a source
    st.push_back(S(0, 3, 8, 1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0)); ex.push_back(STALL); // rt is a source
    st.push_back(S(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0)); ex.push_back(NONE);  // $0 never hazards
    st.push_back(S(0, 8, 3, 1, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0)); ex.push_back(NONE);  // ALU result, bypassed
    foreach (st[i]) begin
      drv(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = {stallF, stallD, flushD, flushE, mdbusy}; e = sb.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL load_use step %0d: got %b expected %b", i, got, e); end
      @(posedge clk); #1;
    end
`ifdef STALL_PERF_CNT_EN
    n_chk++;
    if (stall_cyc !== c0 + 32'd2) begin
      n_fail++; $display("FAIL stall_cycles: got %0d expected %0d", stall_cyc, c0 + 32'd2);
    end
`endif
  endtask

  task automatic test_load_branch();
    stim_t st[$]; logic [4:0] ex[$]; logic [4:0] got, e;
    st.push_back(S(0, 9, 0, 1, 1, 1, 0, 0, 1, 1, 9, 0, 0, 0)); ex.push_back(STALL); // LoadUse
    st.push_back(S(0, 9, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 9)); ex.push_back(STALL); // BranchM
    st.push_back(S(0, 9, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(FLUSH); // resolved, taken
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(NONE);
    foreach (st[i]) begin
      drv(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = {stallF, stallD, flushD, flushE, mdbusy}; e = sb.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL load_branch step %0d: got %b expected %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_branch();
    stim_t st[$]; logic [4:0] ex[$]; logic [4:0] got, e;
    st.push_back(S(0, 1, 5, 1, 1, 1, 0, 0, 0, 1, 5, 0, 0, 0)); ex.push_back(STALL); // BranchE
    st.push_back(S(0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5)); ex.push_back(NONE);  // ALU in MEM, bypassable
    st.push_back(S(0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(FLUSH); // RdE=0, taken
    st.push_back(S(0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0)); ex.push_back(NONE);  // no RegWriteE
    foreach (st[i]) begin
      drv(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = {stallF, stallD, flushD, flushE, mdbusy}; e = sb.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL alu_branch step %0d: got %b expected %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multdiv();
    stim_t st[$]; logic [4:0] ex[$]; logic [4:0] got, e;
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0)); ex.push_back(NONE);         // c0 issue
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(STALL | BUSY); // c1 mflo
    st.push_back(S(0, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(BUSY);         // c2 add
    st.push_back(S(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(STALL | BUSY); // c3 mult
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(NONE);         // c4 mflo ok
    // restart while busy extends occupancy
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); ex.push_back(NONE);         // c0
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(BUSY);         // c1 cnt3
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); ex.push_back(BUSY);         // c2 restart
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(BUSY);         // c3 cnt3
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(BUSY);         // c4 cnt2
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(STALL | BUSY); // c5 cnt1
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(NONE);         // c6 idle
    foreach (st[i]) begin
      drv(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = {stallF, stallD, flushD, flushE, mdbusy}; e = sb.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL multdiv step %0d: got %b expected %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_md();
    stim_t st[$]; logic [4:0] ex[$]; logic [4:0] got, e;
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)); ex.push_back(NONE);  // issue
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(STALL | BUSY);
    st.push_back(S(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(BUSY);  // reset masks stall
    st.push_back(S(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(NONE);  // mflo free
    foreach (st[i]) begin
      drv(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = {stallF, stallD, flushD, flushE, mdbusy}; e = sb.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL reset_mid_md step %0d: got %b expected %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_taken_branch();
    stim_t st[$]; logic [4:0] ex[$]; logic [4:0] got, e;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] c0;
    c0 = flush_cyc;
`endif
    st.push_back(S(0, 2, 3, 1, 1, 1, 0, 0, 0, 1, 7, 0, 1, 6)); ex.push_back(FLUSH);
    st.push_back(S(0, 2, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(NONE);  // not taken
    st.push_back(S(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(NONE);  // not a branch
    foreach (st[i]) begin
      drv(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = {stallF, stallD, flushD, flushE, mdbusy}; e = sb.pop_front(); n_chk++;
      if (got !== e) begin n_fail++; $display("FAIL taken_branch step %0d: got %b expected %b", i, got, e); end
      @(posedge clk); #1;
    end
`ifdef STALL_PERF_CNT_EN
    n_chk++;
    if (flush_cyc !== c0 + 32'd1) begin
      n_fail++; $display("FAIL flush_cycles: got %0d expected %0d", flush_cyc, c0 + 32'd1);
    end
`endif
  endtask

  initial begin
    drv(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_multdiv();
    test_reset_mid_md();
    test_taken_branch();
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
